// File: rtl/e_muldiv_pkg.sv
// e_muldiv_pkg: shared types and arithmetic for the E-stage multiply/divide unit.
//   md_op_e    - operation codes carried on md_op (3 bits)
//   md_state_e - IDLE/RUN control states
//   md_result  - {hi, lo} result of a long operation on latched operands
package e_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // Returns {hi, lo}. Signed division is done on magnitudes so that the
    // 0x80000000 / -1 corner wraps to 0x80000000 without any tool-specific
    // overflow behaviour. A zero divisor is replaced by 1 only to keep the
    // expression well defined; the caller suppresses that write anyway.
    function automatic logic [63:0] md_result(md_op_e op, logic [31:0] a, logic [31:0] b);
        logic [63:0] res;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        res = '0;
        ua  = a;
        ub  = b;
        q   = '0;
        r   = '0;
        case (op)
            // Low 64 bits of a product of sign-extended operands is the signed product.
            MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                ua = a[31] ? (~a + 32'd1) : a;
                ub = b[31] ? (~b + 32'd1) : b;
                if (ub == 32'd0) ub = 32'd1;
                q = ua / ub;
                r = ua % ub;
                if (a[31] ^ b[31]) q = ~q + 32'd1;
                if (a[31])         r = ~r + 32'd1;
                res = {r, q};
            end
            MD_DIVU: begin
                if (ub == 32'd0) ub = 32'd1;
                res = {a % ub, a / ub};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/e_muldiv.sv
// e_muldiv: multi-cycle multiply/divide unit in the Execute stage, owning the
// architectural HI/LO registers.
//   clk, reset  - clock; synchronous active-high reset
//   start       - E-stage instruction is an md operation (qualifies md_op)
//   md_op[2:0]  - md_op_e operation code
//   A, B[31:0]  - forwarded rs / rt values
//   busy        - long operation in flight (feeds the hazard unit)
//   hi, lo      - HI / LO registers
// A long op sampled at edge T keeps busy high for cycles T+1..T+N; hi/lo
// update on the edge that ends cycle T+N. start while busy is ignored.
module e_muldiv
    import e_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    md_op_e           op_q,    op_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic [63:0]      result;
    logic             div_by_zero;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result      = md_result(op_q, a_q, b_q);
        div_by_zero = ((op_q == MD_DIV) || (op_q == MD_DIVU)) && (b_q == 32'd0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT, MD_MULTU: begin
                            op_d    = md_op_e'(md_op);
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            op_d    = md_op_e'(md_op);
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Inputs are not looked at here: start during RUN is dropped.
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!div_by_zero) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (reset) begin
            // NOTE: the latched operands are plain flops, not a memory, so clearing them on reset is cheap and leaves no stale operands behind.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
